// File: rtl/divider_pkg.sv
// divider_pkg: operation/state types and UNROLL legality check for divider_multi
package divider_pkg;
  typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_FIX} state_t;
  localparam logic [4:0] UNROLL_MASK = 5'b10110;
  function automatic bit unroll_ok(int unroll);
    return unroll inside {[1:4]} && UNROLL_MASK[unroll[2:0]];
  endfunction
endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring shift-subtract step; the borrow of the WIDTH+1-bit difference selects restore
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff = shifted - {1'b0, divisor};
  assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/divider_multi.sv
// divider_multi: iterative signed/unsigned divider with stb/cyc/ack handshake; DIVIDER_EARLY_OUT_EN bypasses trivial cases
module divider_multi
  import divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stb_i,
  input  logic             cyc_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ack_o,
  output logic             busy_o
);
  localparam int STEPS = WIDTH / UNROLL;
  localparam int CW = $clog2(STEPS + 1);
  if (!unroll_ok(UNROLL) || WIDTH % UNROLL != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad
    $error("divider_multi: illegal WIDTH/UNROLL combination");
  end
  state_t state, state_next;
  logic [WIDTH-1:0] quo, rem, dvs, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, rem_sel, ack_r, accept, signed_op, early;
  logic [WIDTH-1:0] rem_c [UNROLL+1];
  logic [WIDTH-1:0] quo_c [UNROLL+1];
  assign signed_op = op_i == DIV || op_i == REM;
  assign mag_a = signed_op && dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign mag_b = signed_op && divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
  assign accept = state == ST_IDLE && stb_i && cyc_i && !ack_r;
`ifdef DIVIDER_EARLY_OUT_EN
  assign early = divisor_i == '0 || mag_a < mag_b || mag_b == WIDTH'(1);
`else
  assign early = 1'b0;
`endif
  assign rem_c[0] = rem;
  assign quo_c[0] = quo;
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    divider_step #(.WIDTH(WIDTH)) u_step (
      .rem(rem_c[i]),
      .quo(quo_c[i]),
      .divisor(dvs),
      .rem_next(rem_c[i+1]),
      .quo_next(quo_c[i+1])
    );
  end
  always_ff @(posedge clk_i) state <= rst_i ? ST_IDLE : state_next;
  always_comb
    state_next = state == ST_IDLE ? (accept ? (early ? ST_FIX : ST_DIV) : ST_IDLE)
               : state == ST_DIV ? (cnt == CW'(STEPS - 1) ? ST_FIX : ST_DIV)
               : ST_IDLE;
  // Early-out loads the final magnitudes directly so FIX treats both paths alike.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_r <= 1'b0;
      result_o <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        rem_sel <= op_i == REM || op_i == REMU;
        dvs <= mag_b;
        neg_q <= signed_op && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]) && |divisor_i;
        neg_r <= signed_op && dividend_i[WIDTH-1];
        cnt <= '0;
        quo <= !early ? mag_a : divisor_i == '0 ? '1 : mag_a < mag_b ? '0 : mag_a;
        rem <= early && mag_b != WIDTH'(1) ? mag_a : '0;
      end else if (state == ST_DIV) begin
        quo <= quo_c[UNROLL];
        rem <= rem_c[UNROLL];
        cnt <= cnt + CW'(1);
      end
      if (state == ST_FIX) result_o <= rem_sel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
      ack_r <= state == ST_FIX || (ack_r && stb_i);
    end
  end
  assign ack_o = ack_r & stb_i;
  assign busy_o = state != ST_IDLE;
endmodule

// File: tb/tb_divider_multi.sv
// tb_divider_multi: scoreboard bench running UNROLL=1 and UNROLL=4 instances side by side
module tb_divider_multi;
  import divider_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0, cyc = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic [1:0] op = 2'd0;
  logic [W-1:0] res1, res4;
  logic ack1, ack4, busy1, busy4;
  int checks = 0, errors = 0;
  typedef struct {
    logic [W-1:0] res;
    int lat1;
    int lat4;
    string name;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  divider_multi #(.WIDTH(W), .UNROLL(1)) d1 (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .cyc_i(cyc), .dividend_i(dividend),
    .divisor_i(divisor), .op_i(op), .result_o(res1), .ack_o(ack1), .busy_o(busy1)
  );
  divider_multi #(.WIDTH(W), .UNROLL(4)) d4 (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .cyc_i(cyc), .dividend_i(dividend),
    .divisor_i(divisor), .op_i(op), .result_o(res4), .ack_o(ack4), .busy_o(busy4)
  );
  function automatic logic [W-1:0] model(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
    logic sgn, isrem;
    sgn = o == DIV || o == REM;
    isrem = o == REM || o == REMU;
    if (b == '0) return isrem ? a : '1;
    if (!sgn) return isrem ? a % b : a / b;
    if (a == 32'h8000_0000 && b == '1) return isrem ? '0 : a;
    return isrem ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
  endfunction
  function automatic int lat(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b, int unroll);
    logic sgn, en;
    logic [W-1:0] ma, mb;
    sgn = o == DIV || o == REM;
    ma = sgn && a[W-1] ? -a : a;
    mb = sgn && b[W-1] ? -b : b;
`ifdef DIVIDER_EARLY_OUT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (b == '0 || ma < mb || mb == 1) ? 2 : W / unroll + 2;
  endfunction
  task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    exp_t e;
    op = o;
    dividend = a;
    divisor = b;
    stb = 1'b1;
    cyc = 1'b1;
    e.res = model(o, a, b);
    e.lat1 = lat(o, a, b, 1);
    e.lat4 = lat(o, a, b, 4);
    e.name = name;
    sb.push_back(e);
  endtask
  task automatic start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    @(negedge clk);
    drive(o, a, b, name);
  endtask
  task automatic finish_op();
    exp_t e;
    int n1 = 0, n4 = 0;
    logic [W-1:0] r1, r4;
    e = sb.pop_front();
    for (int n = 1; n <= 100 && (n1 == 0 || n4 == 0); n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        checks++;
        if (busy1 !== 1'b1 || busy4 !== 1'b1) begin
          errors++;
          $display("FAIL %s busy after accept: got %b/%b want 1/1", e.name, busy1, busy4);
        end
      end
      if (ack1 && n1 == 0) begin n1 = n; r1 = res1; end
      if (ack4 && n4 == 0) begin n4 = n; r4 = res4; end
    end
    checks += 4;
    if (n1 != e.lat1) begin errors++; $display("FAIL %s latency u1: got %0d want %0d", e.name, n1, e.lat1); end
    if (n4 != e.lat4) begin errors++; $display("FAIL %s latency u4: got %0d want %0d", e.name, n4, e.lat4); end
    if (r1 !== e.res) begin errors++; $display("FAIL %s result u1: got %h want %h", e.name, r1, e.res); end
    if (r4 !== e.res) begin errors++; $display("FAIL %s result u4: got %h want %h", e.name, r4, e.res); end
  endtask
  task automatic release_bus();
    @(negedge clk);
    stb = 1'b0;
    cyc = 1'b0;
  endtask
  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    start(o, a, b, name);
    finish_op();
    release_bus();
  endtask
  task automatic test_reset();
    stb = 1'b1;
    cyc = 1'b1;
    dividend = 32'd50;
    divisor = 32'd5;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy1 || busy4 || ack1 || ack4 || res1 !== '0 || res4 !== '0) begin
        errors++;
        $display("FAIL reset state: busy %b/%b ack %b/%b res %h/%h want all zero", busy1, busy4, ack1, ack4, res1, res4);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(DIV, 32'd100, -32'sd7, "first_accept_div");
    finish_op();
    release_bus();
  endtask
  task automatic test_vectors();
    run(REM, 32'd100, -32'sd7, "rem_100_m7");
    run(DIVU, 32'h8000_0000, 32'd0, "divu_by_zero");
    run(REMU, 32'h8000_0000, 32'd0, "remu_by_zero");
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run(REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    run(DIVU, 32'd1000, 32'd3, "divu_1000_3");
    run(REMU, 32'd1000, 32'd3, "remu_1000_3");
    run(DIV, -32'sd100, 32'd7, "div_m100_7");
    run(REM, -32'sd100, 32'd7, "rem_m100_7");
    run(DIV, -32'sd5, 32'd0, "div_neg_by_zero");
    run(REM, -32'sd5, 32'd0, "rem_neg_by_zero");
    run(DIVU, 32'd7, 32'd9, "divu_small");
    run(DIV, -32'sd12345, 32'hFFFF_FFFF, "div_by_m1");
  endtask
  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] a, b;
      a = $urandom_range(0, 2) == 0 ? W'($urandom_range(0, 100)) : W'($urandom());
      b = $urandom_range(0, 2) == 0 ? W'($urandom_range(0, 20)) : W'($urandom() >> $urandom_range(0, 24));
      run(2'($urandom_range(0, 3)), a, b, "random");
    end
  endtask
  task automatic test_hold_ack();
    int bad = 0;
    start(DIVU, 32'd1000, 32'd3, "hold_ack");
    finish_op();
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!ack1 || !ack4 || busy1 || busy4) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_ack: %0d cycles lost ack or restarted, want 0", bad); end
    @(negedge clk);
    stb = 1'b0;
    cyc = 1'b0;
    #1;
    checks++;
    if (ack1 !== 1'b0 || ack4 !== 1'b0) begin errors++; $display("FAIL ack_drop: got %b/%b want 0/0", ack1, ack4); end
    run(REMU, 32'd1000, 32'd3, "after_hold");
  endtask
  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    op = DIV;
    dividend = 32'd99999;
    divisor = 32'd13;
    stb = 1'b1;
    cyc = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy1 || busy4 || ack1 || ack4 || res1 !== '0 || res4 !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy %b/%b ack %b/%b res %h/%h want all zero", busy1, busy4, ack1, ack4, res1, res4);
    end
    @(negedge clk);
    rst = 1'b0;
    stb = 1'b0;
    cyc = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy1 || busy4) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid_idle: %0d busy cycles want 0", bad); end
    run(DIV, 32'd99999, 32'd13, "after_reset_mid");
  endtask
  task automatic test_abandon();
    int bad = 0;
    logic [W-1:0] want;
    want = model(DIVU, 32'd1000, 32'd7);
    @(negedge clk);
    op = DIVU;
    dividend = 32'd1000;
    divisor = 32'd7;
    stb = 1'b1;
    cyc = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    cyc = 1'b0;
    op = REM;
    dividend = 32'd5;
    divisor = 32'd1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ack1 || ack4) bad++;
    end
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL abandon_ack: %0d cycles with ack want 0", bad); end
    if (res1 !== want || res4 !== want) begin
      errors++;
      $display("FAIL abandon_result: got %h/%h want %h", res1, res4, want);
    end
    run(REM, 32'd5, 32'd1, "after_abandon");
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_hold_ack();
    test_reset_mid();
    test_abandon();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
